morse_decoder: RTL and testbench

//  Downstream consumer of the Morse serial stream (1 bit per unit, high = mark).

---
 rtl/morse_decoder.sv | 159 +++++++++++++++
 tb/tb_morse_decoder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/morse_decoder.sv
// morse_decoder
//   Receives a Morse serial stream (one bit per unit, 1 = mark), measures
//   mark/space run lengths in units, classifies marks as dot or dash, and
//   decodes letters S..Z into a 3-bit code once a 3-unit gap is seen.
//   Unknown patterns and patterns with more than 4 symbols raise letter_err.
//
// Ports
//   clk           in   system clock
//   reset_n       in   synchronous, active-low reset
//   serial_in     in   Morse stream, 1 = mark, 0 = space (asynchronous)
//   letter        out  [2:0] decoded letter code, held until the next valid letter
//   letter_valid  out  1-cycle pulse, letter has just been updated
//   letter_err    out  1-cycle pulse, unknown or overlong pattern
//   busy          out  high while at least one symbol is buffered
module morse_decoder #(
  parameter int UNIT_CYCLES = 25000000,
  parameter int CNT_W       = 26
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       serial_in,
  output logic [2:0] letter,
  output logic       letter_valid,
  output logic       letter_err,
  output logic       busy
);

  localparam logic [CNT_W-1:0] UNIT_LAST = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SMP_AT    = CNT_W'(UNIT_CYCLES / 2 - 1);

  // Pattern lookup: returns {ok, code}. The first symbol received sits in
  // the most significant used bit of sym_bits; dot = 0, dash = 1.
  function automatic logic [3:0] decode_fn(input logic [2:0] cnt,
                                           input logic [3:0] bits);
    logic [3:0] res;
    res = 4'b0000;
    case (cnt)
      3'd1: if (bits[0]) res = {1'b1, 3'b001};            // T
      3'd3: begin
        case (bits[2:0])
          3'b000:  res = {1'b1, 3'b000};                  // S
          3'b001:  res = {1'b1, 3'b010};                  // U
          3'b011:  res = {1'b1, 3'b100};                  // W
          default: res = 4'b0000;
        endcase
      end
      3'd4: begin
        case (bits)
          4'b0001: res = {1'b1, 3'b011};                  // V
          4'b1001: res = {1'b1, 3'b101};                  // X
          4'b1011: res = {1'b1, 3'b110};                  // Y
          4'b1100: res = {1'b1, 3'b111};                  // Z
          default: res = 4'b0000;
        endcase
      end
      default: res = 4'b0000;
    endcase
    return res;
  endfunction

  logic             sync1_q,        sync1_d;
  logic             s_q,            s_d;
  logic             s_prev_q,       s_prev_d;
  logic [CNT_W-1:0] unit_cnt_q,     unit_cnt_d;
  logic [2:0]       run_cnt_q,      run_cnt_d;
  logic [3:0]       sym_bits_q,     sym_bits_d;
  logic [2:0]       sym_cnt_q,      sym_cnt_d;
  logic [2:0]       letter_q,       letter_d;
  logic             letter_valid_q, letter_valid_d;
  logic             letter_err_q,   letter_err_d;
  logic             busy_q,         busy_d;

  logic             edge_w;
  logic             fall_w;
  logic             smp_w;
  logic             letter_end_w;
  logic [3:0]       dec_w;

  always_comb begin
    edge_w = s_q ^ s_prev_q;
    fall_w = s_prev_q & ~s_q;
    smp_w  = (unit_cnt_q == SMP_AT);

    sync1_d  = serial_in;
    s_d      = sync1_q;
    s_prev_d = s_q;

    // Timer restarts on every edge so that smp lands mid-unit.
    if (edge_w || unit_cnt_q == UNIT_LAST) begin
      unit_cnt_d = '0;
    end else begin
      unit_cnt_d = unit_cnt_q + 1'b1;
    end

    // Edge wins over smp; count saturates at 7 during long idle space.
    if (edge_w) begin
      run_cnt_d = 3'd0;
    end else if (smp_w && run_cnt_q != 3'd7) begin
      run_cnt_d = run_cnt_q + 3'd1;
    end else begin
      run_cnt_d = run_cnt_q;
    end

    // Third space unit just completed with symbols pending. An edge cycle
    // cannot qualify because its run count is being cleared.
    letter_end_w = smp_w & ~s_q & ~edge_w & (run_cnt_q == 3'd2) & (sym_cnt_q != 3'd0);

    sym_bits_d = sym_bits_q;
    sym_cnt_d  = sym_cnt_q;
    if (letter_end_w) begin
      sym_bits_d = 4'b0000;
      sym_cnt_d  = 3'd0;
    end else if (fall_w && run_cnt_q != 3'd0) begin
      // A mark shorter than one sample is a glitch and is dropped.
      sym_bits_d = {sym_bits_q[2:0], (run_cnt_q >= 3'd2)};
      sym_cnt_d  = (sym_cnt_q == 3'd5) ? 3'd5 : sym_cnt_q + 3'd1;
    end

    dec_w          = decode_fn(sym_cnt_q, sym_bits_q);
    letter_valid_d = letter_end_w & dec_w[3];
    letter_err_d   = letter_end_w & ~dec_w[3];
    letter_d       = (letter_end_w && dec_w[3]) ? dec_w[2:0] : letter_q;
    busy_d         = (sym_cnt_d != 3'd0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q        <= 1'b0;
      s_q            <= 1'b0;
      s_prev_q       <= 1'b0;
      unit_cnt_q     <= '0;
      run_cnt_q      <= 3'd0;
      sym_bits_q     <= 4'b0000;
      sym_cnt_q      <= 3'd0;
      letter_q       <= 3'b000;
      letter_valid_q <= 1'b0;
      letter_err_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      s_q            <= s_d;
      s_prev_q       <= s_prev_d;
      unit_cnt_q     <= unit_cnt_d;
      run_cnt_q      <= run_cnt_d;
      sym_bits_q     <= sym_bits_d;
      sym_cnt_q      <= sym_cnt_d;
      letter_q       <= letter_d;
      letter_valid_q <= letter_valid_d;
      letter_err_q   <= letter_err_d;
      busy_q         <= busy_d;
    end
  end

  assign letter       = letter_q;
  assign letter_valid = letter_valid_q;
  assign letter_err   = letter_err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_morse_decoder.sv
// tb_morse_decoder
//   Directed bench for morse_decoder with UNIT_CYCLES = 8. Serial input is
//   driven in whole units on the falling clock edge; a monitor counts the
//   output pulses and records the letter, busy and time at each valid pulse.
`timescale 1ns/1ps
module tb_morse_decoder;

  localparam int UC = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       serial_in;
  logic [2:0] letter;
  logic       letter_valid;
  logic       letter_err;
  logic       busy;

  int  checks = 0;
  int  errors = 0;

  int  n_valid = 0;
  int  n_err = 0;
  int  n_both = 0;
  int  last_letter = 0;
  int  busy_at_valid = 0;
  time t_valid = 0;

  morse_decoder #(.UNIT_CYCLES(UC), .CNT_W(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .serial_in    (serial_in),
    .letter       (letter),
    .letter_valid (letter_valid),
    .letter_err   (letter_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (letter_valid) begin
      n_valid       = n_valid + 1;
      last_letter   = int'(letter);
      busy_at_valid = int'(busy);
      t_valid       = $time;
    end
    if (letter_err) n_err = n_err + 1;
    if (letter_valid && letter_err) n_both = n_both + 1;
  end

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Drives one unit per character, starting on the current falling edge.
  task automatic send(input string pat);
    for (int i = 0; i < pat.len(); i++) begin
      serial_in = (pat.getc(i) == "1");
      repeat (UC) @(negedge clk);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  v0;
    int  e0;
    time t_drive;

    // Reset with serial_in toggling.
    reset_n   = 1'b0;
    serial_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("rst_letter", int'(letter), 0);
      check("rst_valid",  int'(letter_valid), 0);
      check("rst_err",    int'(letter_err), 0);
      check("rst_busy",   int'(busy), 0);
      serial_in = ~serial_in;
    end
    @(negedge clk);
    serial_in = 1'b0;
    reset_n   = 1'b1;
    send("00");

    // S: three dots, then letter gap. Pulse expected 23 clk after the last fall.
    v0 = n_valid; e0 = n_err;
    send("10");
    check("s_busy_mid", int'(busy), 1);
    send("101");
    t_drive = $time;
    send("0000");
    settle();
    check("s_valid_cnt", n_valid - v0, 1);
    check("s_err_cnt",   n_err - e0, 0);
    check("s_letter",    last_letter, 0);
    check("s_busy_at_valid", busy_at_valid, 0);
    check("s_latency",   int'(t_valid - t_drive), 23 * 10);
    check("s_busy_after", int'(busy), 0);
    @(negedge clk);

    // Y then T.
    v0 = n_valid; e0 = n_err;
    send("11101011101110000");
    settle();
    check("y_valid_cnt", n_valid - v0, 1);
    check("y_err_cnt",   n_err - e0, 0);
    check("y_letter",    int'(letter), 6);
    @(negedge clk);
    v0 = n_valid; e0 = n_err;
    send("1110000");
    settle();
    check("t_valid_cnt", n_valid - v0, 1);
    check("t_err_cnt",   n_err - e0, 0);
    check("t_letter",    int'(letter), 1);
    @(negedge clk);

    // E is not in the table.
    v0 = n_valid; e0 = n_err;
    send("10000");
    settle();
    check("e_err_cnt",   n_err - e0, 1);
    check("e_valid_cnt", n_valid - v0, 0);
    check("e_letter_held", int'(letter), 1);
    @(negedge clk);

    // Five dots overflow the symbol buffer.
    v0 = n_valid; e0 = n_err;
    send("1010101010000");
    settle();
    check("ovf_err_cnt",   n_err - e0, 1);
    check("ovf_valid_cnt", n_valid - v0, 0);
    check("ovf_letter_held", int'(letter), 1);
    @(negedge clk);

    // Two-clock glitch inside idle space.
    v0 = n_valid; e0 = n_err;
    serial_in = 1'b1;
    repeat (2) @(negedge clk);
    serial_in = 1'b0;
    repeat (6) @(negedge clk);
    check("glitch_busy", int'(busy), 0);
    send("0000");
    settle();
    check("glitch_valid_cnt", n_valid - v0, 0);
    check("glitch_err_cnt",   n_err - e0, 0);
    @(negedge clk);

    // Reset mid-letter discards the two buffered dots.
    send("1010");
    check("mid_busy_before", int'(busy), 1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("mid_busy_reset",   int'(busy), 0);
    check("mid_letter_reset", int'(letter), 0);
    v0 = n_valid; e0 = n_err;
    send("1110000");
    settle();
    check("mid_valid_cnt", n_valid - v0, 1);
    check("mid_err_cnt",   n_err - e0, 0);
    check("mid_letter",    int'(letter), 1);

    check("never_both", n_both, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
